level_controller: RTL and testbench

- Parametrised successor to the static per-level modules: the same tile map, sprite positions, timer and win/lose interface, driven by live game logic.
- Owns a mutable copy of the level tile map and moves Mario from the switches and jump button with tile collision.
- Runs a patrolling goomba, collects tokens, counts down the level timer and latches win/lose.
- Sits between the input debouncers and the VGA renderer; one instance per level, configured by parameters and the level_map input.

---
 rtl/level_controller.sv | 214 +++++++++++++++++++++
 tb/tb_level_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/level_controller.sv
// One playable level: owns the live tile map and runs Mario, the goomba, tokens,
// the level timer and the latched win/lose outcome, all stepped on a 60 Hz game tick.
module level_controller #(
  parameter int BDR = 0,
  parameter int SKY = 1,
  parameter int BLK = 2,
  parameter int GND = 3,
  parameter int TKN = 4,
  parameter int CK1 = 5,
  parameter int CK2 = 6,
  parameter int ROWS = 12,
  parameter int COLS = 17,
  parameter int BLOCK_WIDTH = 40,
  parameter int CHARACTER_WIDTH = 42,
  parameter int SCREEN_WIDTH = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int CLOCK_HZ = 25000000,
  parameter int TICK_DIV = 416667,
  parameter int TIME_LIMIT = 60,
  parameter int START_X = 100,
  parameter int START_Y = 360,
  parameter int WALK_SPEED = 2,
  parameter int JUMP_SPEED = 4,
  parameter int FALL_SPEED = 4,
  parameter int JUMP_TICKS = 20,
  parameter int GOOMBA_Y = 360,
  parameter int GOOMBA_MIN_X = 400,
  parameter int GOOMBA_MAX_X = 560,
  parameter int TOKEN_COUNT = 2
) (
  input  logic                            vga_clock,
  input  logic                            reset,
  input  logic [ROWS-1:0][COLS-1:0][7:0]  level_map,
  input  logic                            left_switch,
  input  logic                            right_switch,
  input  logic                            jump_button,
  output logic [ROWS-1:0][COLS-1:0][7:0]  background,
  output logic [31:0]                     mario_x,
  output logic [31:0]                     mario_y,
  output logic [31:0]                     goomba_x,
  output logic [31:0]                     goomba_y,
  output logic [31:0]                     seconds,
  output logic                            win,
  output logic                            lose,
  output logic [9:0]                      leds
);

  localparam int RBITS = $clog2(ROWS);
  localparam int CBITS = $clog2(COLS);

  typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} motion_e;
  typedef enum logic [1:0] {PLAY = 2'd0, WON = 2'd1, LOST = 2'd2} game_e;

  logic [ROWS-1:0][COLS-1:0][7:0] bg_q, bg_d;
  int      marioX_q, marioX_d, marioY_q, marioY_d;
  int      goombaX_q, goombaX_d;
  logic    goombaRight_q, goombaRight_d;
  int      seconds_q, seconds_d;
  logic [3:0] tokens_q, tokens_d;
  int      jumpCnt_q, jumpCnt_d;
  int      tickCnt_q, tickCnt_d, secCnt_q, secCnt_d;
  motion_e motion_q, motion_d;
  game_e   game_q, game_d;

  logic tick, sec, overlap, loseNow, winNow;
  int   tx, lead, ny, cx, cy;
  logic [RBITS-1:0] rowIdx;
  logic [CBITS-1:0] colIdx;

  // Anything off the map behaves like border so sprites can never leave it.
  function automatic logic [7:0] tileAt(input logic [ROWS-1:0][COLS-1:0][7:0] map,
                                        input int px, input int py);
    int r, c;
    logic [7:0] t;
    r = py / BLOCK_WIDTH;
    c = px / BLOCK_WIDTH;
    if (px < 0 || py < 0 || r >= ROWS || c >= COLS) t = 8'(BDR);
    else t = map[r[RBITS-1:0]][c[CBITS-1:0]];
    return t;
  endfunction

  function automatic logic solidAt(input logic [ROWS-1:0][COLS-1:0][7:0] map,
                                   input int px, input int py);
    logic [7:0] t;
    t = tileAt(map, px, py);
    return (t == 8'(BDR) || t == 8'(BLK) || t == 8'(GND)) && t != 8'(CK1) && t != 8'(CK2);
  endfunction

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      bg_q          <= level_map;
      marioX_q      <= START_X;
      marioY_q      <= START_Y;
      goombaX_q     <= GOOMBA_MIN_X;
      goombaRight_q <= 1'b1;
      seconds_q     <= TIME_LIMIT;
      tokens_q      <= '0;
      jumpCnt_q     <= 0;
      tickCnt_q     <= 0;
      secCnt_q      <= 0;
      motion_q      <= FALL;
      game_q        <= PLAY;
    end else begin
      bg_q          <= bg_d;
      marioX_q      <= marioX_d;
      marioY_q      <= marioY_d;
      goombaX_q     <= goombaX_d;
      goombaRight_q <= goombaRight_d;
      seconds_q     <= seconds_d;
      tokens_q      <= tokens_d;
      jumpCnt_q     <= jumpCnt_d;
      tickCnt_q     <= tickCnt_d;
      secCnt_q      <= secCnt_d;
      motion_q      <= motion_d;
      game_q        <= game_d;
    end
  end

  always_comb begin
    bg_d = bg_q; marioX_d = marioX_q; marioY_d = marioY_q;
    goombaX_d = goombaX_q; goombaRight_d = goombaRight_q;
    seconds_d = seconds_q; tokens_d = tokens_q; jumpCnt_d = jumpCnt_q;
    motion_d = motion_q; game_d = game_q;
    tx = marioX_q; lead = marioX_q; ny = marioY_q; cx = 0; cy = 0;
    rowIdx = '0; colIdx = '0;
    overlap = 1'b0; loseNow = 1'b0; winNow = 1'b0;

    tick = (tickCnt_q == TICK_DIV - 1);
    sec  = (secCnt_q == CLOCK_HZ - 1);
    tickCnt_d = tick ? 0 : tickCnt_q + 1;
    secCnt_d  = sec ? 0 : secCnt_q + 1;

    if (game_q == PLAY && sec && seconds_q != 0) seconds_d = seconds_q - 1;

    if (game_q == PLAY && tick) begin
      if (left_switch != right_switch) begin
        tx = right_switch ? marioX_q + WALK_SPEED : marioX_q - WALK_SPEED;
        if (tx < 0) tx = 0;
        if (tx > SCREEN_WIDTH - CHARACTER_WIDTH) tx = SCREEN_WIDTH - CHARACTER_WIDTH;
        lead = right_switch ? tx + CHARACTER_WIDTH - 1 : tx;
        if (!solidAt(bg_q, lead, marioY_q) && !solidAt(bg_q, lead, marioY_q + CHARACTER_WIDTH - 1))
          marioX_d = tx;
      end

      // Vertical motion sees the pre-tick x so both axes resolve from one snapshot.
      case (motion_q)
        GROUND: begin
          if (jump_button) begin
            motion_d  = RISE;
            jumpCnt_d = 0;
          end else if (!solidAt(bg_q, marioX_q, marioY_q + CHARACTER_WIDTH) &&
                       !solidAt(bg_q, marioX_q + CHARACTER_WIDTH - 1, marioY_q + CHARACTER_WIDTH))
            motion_d = FALL;
        end
        RISE: begin
          if (solidAt(bg_q, marioX_q, marioY_q - JUMP_SPEED) ||
              solidAt(bg_q, marioX_q + CHARACTER_WIDTH - 1, marioY_q - JUMP_SPEED))
            motion_d = FALL;
          else begin
            marioY_d  = marioY_q - JUMP_SPEED;
            jumpCnt_d = jumpCnt_q + 1;
            if (jumpCnt_q + 1 >= JUMP_TICKS) motion_d = FALL;
          end
        end
        default: begin
          ny = marioY_q + FALL_SPEED;
          if (solidAt(bg_q, marioX_q, ny + CHARACTER_WIDTH) ||
              solidAt(bg_q, marioX_q + CHARACTER_WIDTH - 1, ny + CHARACTER_WIDTH)) begin
            marioY_d = (ny + CHARACTER_WIDTH) / BLOCK_WIDTH * BLOCK_WIDTH - CHARACTER_WIDTH;
            motion_d = GROUND;
          end else
            marioY_d = ny;
        end
      endcase

      if (goombaRight_q) begin
        if (goombaX_q >= GOOMBA_MAX_X) goombaRight_d = 1'b0;
        else goombaX_d = goombaX_q + 1;
      end else begin
        if (goombaX_q <= GOOMBA_MIN_X) goombaRight_d = 1'b1;
        else goombaX_d = goombaX_q - 1;
      end

      cx = marioX_d + CHARACTER_WIDTH / 2;
      cy = marioY_d + CHARACTER_WIDTH / 2;
      if (tileAt(bg_q, cx, cy) == 8'(TKN)) begin
        rowIdx = RBITS'(cy / BLOCK_WIDTH);
        colIdx = CBITS'(cx / BLOCK_WIDTH);
        bg_d[rowIdx][colIdx] = 8'(SKY);
        tokens_d = tokens_q + 4'd1;
      end

      overlap = marioX_d < goombaX_d + CHARACTER_WIDTH && goombaX_d < marioX_d + CHARACTER_WIDTH &&
                marioY_d < GOOMBA_Y + CHARACTER_WIDTH && GOOMBA_Y < marioY_d + CHARACTER_WIDTH;
      loseNow = seconds_d == 0 || marioY_d > SCREEN_HEIGHT - CHARACTER_WIDTH || overlap;
      winNow  = tokens_d == 4'(TOKEN_COUNT);
      if (loseNow) game_d = LOST;
      else if (winNow) game_d = WON;
    end
  end

  always_comb begin
    background = bg_q;
    mario_x    = marioX_q;
    mario_y    = marioY_q;
    goomba_x   = goombaX_q;
    goomba_y   = GOOMBA_Y;
    seconds    = seconds_q;
    win        = (game_q == WON);
    lose       = (game_q == LOST);
    leds       = {2'b00, motion_q, game_q == LOST, game_q == WON, tokens_q};
  end

endmodule

// File: tb/tb_level_controller.sv
// Directed bench for level_controller: a walking/jumping vector table plus
// hand-written token, timer, goomba and asynchronous-reset sequences.
module tb_level_controller;

  localparam int TICK = 4;
  localparam int HZ = 100;

  logic clk;
  logic resetN;
  logic [11:0][16:0][7:0] levelMap;
  logic leftSw, rightSw, jumpBtn;
  logic [11:0][16:0][7:0] background;
  logic [31:0] marioX, marioY, goombaX, goombaY, secondsOut;
  logic winOut, loseOut;
  logic [9:0] leds;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic left;
    logic right;
    logic jump;
    int   ticks;
    int   expX;
    int   expY;
    int   expMotion;
  } vecT;

  vecT vecs[18];

  level_controller #(.CLOCK_HZ(HZ), .TICK_DIV(TICK)) dut (
    .vga_clock(clk), .reset(resetN), .level_map(levelMap),
    .left_switch(leftSw), .right_switch(rightSw), .jump_button(jumpBtn),
    .background(background), .mario_x(marioX), .mario_y(marioY),
    .goomba_x(goombaX), .goomba_y(goombaY), .seconds(secondsOut),
    .win(winOut), .lose(loseOut), .leds(leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitClocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic j, input int ticks);
    leftSw = l; rightSw = r; jumpBtn = j;
    waitClocks(ticks * TICK);
  endtask

  // Ground on rows 10-11, sky everywhere else.
  task automatic buildBaseMap();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++)
        levelMap[r][c] = (r >= 10) ? 8'd3 : 8'd1;
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    leftSw = 1'b0; rightSw = 1'b0; jumpBtn = 1'b0;
    waitClocks(2);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic asyncResetPulse();
    #2;
    resetN = 1'b0;
    #1;
  endtask

  initial begin
    resetN = 1'b1;
    leftSw = 1'b0; rightSw = 1'b0; jumpBtn = 1'b0;
    buildBaseMap();

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1,   100, 358, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 10,  120, 358, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 5,   120, 358, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 3,   120, 358, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1,   120, 358, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 19,  120, 282, 1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1,   120, 278, 2};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 19,  120, 354, 2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1,   120, 358, 0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 5,   110, 358, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 80,  238, 358, 0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 200, 0,   358, 0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 3,   6,   358, 0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1,   6,   358, 1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 9,   6,   322, 1};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1,   6,   322, 2};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8,   6,   354, 2};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1,   6,   358, 0};

    // Idle level: reset values, landing from the spawn height, timer and goomba patrol.
    resetDut();
    checkOutput("reset mario_x", marioX, 100);
    checkOutput("reset mario_y", marioY, 360);
    checkOutput("reset goomba_x", goombaX, 400);
    checkOutput("reset goomba_y", goombaY, 360);
    checkOutput("reset seconds", secondsOut, 60);
    checkOutput("reset win", {31'd0, winOut}, 0);
    checkOutput("reset lose", {31'd0, loseOut}, 0);
    checkOutput("reset leds", {22'd0, leds}, 32'h080);
    checkOutput("reset bg ground", {24'd0, background[10][0]}, 3);
    checkOutput("reset bg sky", {24'd0, background[0][0]}, 1);
    releaseReset();
    waitClocks(8);
    checkOutput("landed y", marioY, 358);
    checkOutput("landed motion", {30'd0, leds[7:6]}, 0);
    waitClocks(191);
    checkOutput("seconds before 2s", secondsOut, 59);
    waitClocks(1);
    checkOutput("seconds at 2s", secondsOut, 58);
    waitClocks(280);
    checkOutput("idle mario_x", marioX, 100);
    checkOutput("idle mario_y", marioY, 358);
    checkOutput("idle motion", {30'd0, leds[7:6]}, 0);
    checkOutput("idle goomba_x", goombaX, 520);
    checkOutput("idle seconds", secondsOut, 56);

    // Walking and jumping table against a block column and a low ceiling.
    buildBaseMap();
    levelMap[8][7] = 8'd2; levelMap[9][7] = 8'd2;
    levelMap[7][0] = 8'd2; levelMap[7][1] = 8'd2;
    resetDut();
    releaseReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].left, vecs[i].right, vecs[i].jump, vecs[i].ticks);
      checkOutput($sformatf("vec%0d x", i), marioX, vecs[i].expX);
      checkOutput($sformatf("vec%0d y", i), marioY, vecs[i].expY);
      checkOutput($sformatf("vec%0d motion", i), {30'd0, leds[7:6]}, vecs[i].expMotion);
    end
    checkOutput("walk lose", {31'd0, loseOut}, 0);

    // Tokens at (9,2) and (9,5): collect both, win freezes the level.
    buildBaseMap();
    levelMap[9][2] = 8'd4; levelMap[9][5] = 8'd4;
    resetDut();
    releaseReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("token1 present", {24'd0, background[9][2]}, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("token1 x", marioX, 98);
    checkOutput("token1 taken", {24'd0, background[9][2]}, 1);
    checkOutput("tokens 1", {28'd0, leds[3:0]}, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 40);
    checkOutput("pre-win x", marioX, 178);
    checkOutput("pre-win win", {31'd0, winOut}, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("win x", marioX, 180);
    checkOutput("win", {31'd0, winOut}, 1);
    checkOutput("win led", {31'd0, leds[4]}, 1);
    checkOutput("tokens 2", {28'd0, leds[3:0]}, 2);
    checkOutput("token2 taken", {24'd0, background[9][5]}, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 10);
    checkOutput("frozen x", marioX, 180);
    checkOutput("frozen goomba", goombaX, 443);
    checkOutput("frozen seconds", secondsOut, 59);
    checkOutput("frozen win", {31'd0, winOut}, 1);
    asyncResetPulse();
    checkOutput("async token1 restored", {24'd0, background[9][2]}, 4);
    checkOutput("async token2 restored", {24'd0, background[9][5]}, 4);
    checkOutput("async win", {31'd0, winOut}, 0);
    checkOutput("async mario_x", marioX, 100);
    checkOutput("async mario_y", marioY, 360);
    checkOutput("async seconds", secondsOut, 60);

    // Reset dropped in the middle of a rise.
    resetDut();
    releaseReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    checkOutput("midjump y", marioY, 338);
    asyncResetPulse();
    checkOutput("midjump reset y", marioY, 360);
    checkOutput("midjump reset x", marioX, 100);
    checkOutput("midjump reset leds", {22'd0, leds}, 32'h080);

    // Timer runs out; the final second and the tick coincide.
    buildBaseMap();
    resetDut();
    releaseReset();
    waitClocks(5996);
    checkOutput("timer seconds 1", secondsOut, 1);
    checkOutput("timer lose early", {31'd0, loseOut}, 0);
    waitClocks(4);
    checkOutput("timer seconds 0", secondsOut, 0);
    checkOutput("timer lose", {31'd0, loseOut}, 1);
    checkOutput("timer lose led", {31'd0, leds[5]}, 1);
    waitClocks(200);
    checkOutput("timer seconds hold", secondsOut, 0);
    checkOutput("timer lose hold", {31'd0, loseOut}, 1);

    // Goomba turns at the right limit and walks back into Mario.
    resetDut();
    releaseReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 159);
    checkOutput("goomba at max", goombaX, 560);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("goomba reversal tick", goombaX, 560);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("goomba heading left", goombaX, 559);
    applyStimulus(1'b0, 1'b1, 1'b0, 31);
    checkOutput("near miss mario_x", marioX, 484);
    checkOutput("near miss goomba_x", goombaX, 528);
    checkOutput("near miss lose", {31'd0, loseOut}, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("collision lose", {31'd0, loseOut}, 1);
    checkOutput("collision mario_x", marioX, 486);
    checkOutput("collision goomba_x", goombaX, 527);
    applyStimulus(1'b0, 1'b1, 1'b0, 5);
    checkOutput("lost frozen mario_x", marioX, 486);
    checkOutput("lost frozen goomba_x", goombaX, 527);
    asyncResetPulse();
    checkOutput("after lose reset lose", {31'd0, loseOut}, 0);
    checkOutput("after lose reset goomba", goombaX, 400);
    checkOutput("after lose reset seconds", secondsOut, 60);

    // Second token grabbed on the same tick the goomba touches Mario.
    buildBaseMap();
    levelMap[9][4] = 8'd4; levelMap[9][12] = 8'd4;
    resetDut();
    releaseReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 40);
    applyStimulus(1'b0, 1'b1, 1'b0, 179);
    checkOutput("tie pre mario_x", marioX, 458);
    checkOutput("tie pre tokens", {28'd0, leds[3:0]}, 1);
    checkOutput("tie pre lose", {31'd0, loseOut}, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkOutput("tie mario_x", marioX, 460);
    checkOutput("tie lose", {31'd0, loseOut}, 1);
    checkOutput("tie win", {31'd0, winOut}, 0);
    checkOutput("tie win led", {31'd0, leds[4]}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
